// File: rtl/detect_pkg.sv
// Shared definitions for the detect event counter: FSM state encodings and
// default parameter values.
package detect_pkg;

  localparam int unsigned CntWDefault   = 8;
  localparam int unsigned WinLenDefault = 64;
  localparam int unsigned ThreshDefault = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } run_state_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rpt_state_e;

endpackage

// File: rtl/detect_event_counter_if.sv
// Report handshake bundle: valid/ready with the reported count and alarm.
interface detect_event_counter_if #(
  parameter int unsigned CNT_W = detect_pkg::CntWDefault
) ();

  logic             rptValid;
  logic             rptReady;
  logic [CNT_W-1:0] rptCount;
  logic             alarmAH;

  modport master (
    output rptValid,
    output rptCount,
    output alarmAH,
    input  rptReady
  );

  modport slave (
    input  rptValid,
    input  rptCount,
    input  alarmAH,
    output rptReady
  );

endinterface

// File: rtl/win_timer.sv
// Window timer: run FSM plus a 0..WIN_LEN-1 cycle counter. winEnd pulses on
// the last cycle of each window; the count is cleared whenever enAH is low.
module win_timer
  import detect_pkg::*;
#(
  parameter int unsigned WIN_LEN = WinLenDefault
) (
  input  logic sysClk,
  input  logic resetH,
  input  logic enAH,
  output logic runAH,
  output logic winEnd
);

  localparam int unsigned     WinW    = $clog2(WIN_LEN);
  localparam logic [WinW-1:0] LastCnt = WinW'(WIN_LEN - 1);

  run_state_e      state_q, state_d;
  logic [WinW-1:0] win_cnt_q, win_cnt_d;

  assign runAH  = (state_q == StRun);
  // A window-end cycle is still honoured when enAH drops on that same cycle.
  assign winEnd = (state_q == StRun) && (win_cnt_q == LastCnt);

  // Next state of the run FSM and the window position.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (enAH) state_d = StRun;
      end
      StRun: begin
        if (!enAH) begin
          state_d = StIdle;
        end else if (!winEnd) begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge sysClk) begin
    if (resetH) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/detect_event_counter.sv
// Detect event counter: counts detector pulses per fixed window and offers
// each window total as a report over a valid/ready handshake, with a
// threshold alarm and a sticky overflow flag for dropped reports.
// Build option: define DETECT_CNT_SAT_EN to saturate the event count at
// 2^CNT_W-1 instead of wrapping.
module detect_event_counter
  import detect_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned WIN_LEN = WinLenDefault,
  parameter int unsigned THRESH  = ThreshDefault
) (
  input  logic                   sysClk,
  input  logic                   resetH,
  input  logic                   enAH,
  input  logic                   detAH,
  input  logic                   clrOvfAH,
  output logic                   ovfAH,
  detect_event_counter_if.master rpt
);

  localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

  logic             run;
  logic             win_end;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [CNT_W-1:0] win_total;
  rpt_state_e       rpt_state_q, rpt_state_d;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;

  win_timer #(
    .WIN_LEN(WIN_LEN)
  ) u_win_timer (
    .sysClk(sysClk),
    .resetH(resetH),
    .enAH  (enAH),
    .runAH (run),
    .winEnd(win_end)
  );

  // Running total including this cycle's detection.
  always_comb begin
`ifdef DETECT_CNT_SAT_EN
    win_total = (detAH && (evt_cnt_q != '1)) ? evt_cnt_q + 1'b1 : evt_cnt_q;
`else
    win_total = evt_cnt_q + CNT_W'(detAH);
`endif
  end

  // Event count: accumulates inside a window, clears at window end or when idle.
  always_comb begin
    evt_cnt_d = '0;
    if (run && enAH && !win_end) evt_cnt_d = win_total;
  end

  // Report FSM: load on window end, drop and flag overflow if still unaccepted.
  always_comb begin
    rpt_state_d = rpt_state_q;
    rpt_count_d = rpt_count_q;
    alarm_d     = alarm_q;
    ovf_d       = ovf_q;
    if (clrOvfAH) ovf_d = 1'b0;
    unique case (rpt_state_q)
      StEmpty: begin
        if (win_end) begin
          rpt_state_d = StFull;
          rpt_count_d = win_total;
          alarm_d     = (win_total >= ThreshVal);
        end
      end
      StFull: begin
        if (win_end) begin
          if (rpt.rptReady) begin
            rpt_count_d = win_total;
            alarm_d     = (win_total >= ThreshVal);
          end else begin
            // Set wins over a coincident clear.
            ovf_d = 1'b1;
          end
        end else if (rpt.rptReady) begin
          rpt_state_d = StEmpty;
          alarm_d     = 1'b0;
        end
      end
      default: rpt_state_d = StEmpty;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge sysClk) begin
    if (resetH) begin
      evt_cnt_q   <= '0;
      rpt_state_q <= StEmpty;
      rpt_count_q <= '0;
      alarm_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      evt_cnt_q   <= evt_cnt_d;
      rpt_state_q <= rpt_state_d;
      rpt_count_q <= rpt_count_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rpt.rptValid = (rpt_state_q == StFull);
  assign rpt.rptCount = rpt_count_q;
  assign rpt.alarmAH  = alarm_q;
  assign ovfAH        = ovf_q;

endmodule

// File: tb/tb_detect_event_counter.sv
// Bench for detect_event_counter: a default instance (CNT_W=8, WIN_LEN=64,
// THRESH=4) and a narrow instance (CNT_W=3, WIN_LEN=16, THRESH=5) share all
// stimulus. Directed scenarios check fixed values; the random scenario checks
// both instances every cycle against a window/report model.
module tb_detect_event_counter;

  localparam int unsigned CntW0 = 8, WinLen0 = 64, Thresh0 = 4;
  localparam int unsigned CntW1 = 3, WinLen1 = 16, Thresh1 = 5;

`ifdef DETECT_CNT_SAT_EN
  localparam logic [2:0] SatCnt   = 3'd7;
  localparam logic       SatAlarm = 1'b1;
`else
  localparam logic [2:0] SatCnt   = 3'd2;
  localparam logic       SatAlarm = 1'b0;
`endif

  logic sysClk = 1'b0;
  logic resetH, enAH, detAH, rptReady, clrOvfAH;
  logic ovf0, ovf1;
  int   checks = 0;
  int   errors = 0;

  detect_event_counter_if #(.CNT_W(CntW0)) rpt0 ();
  detect_event_counter_if #(.CNT_W(CntW1)) rpt1 ();
  assign rpt0.rptReady = rptReady;
  assign rpt1.rptReady = rptReady;

  detect_event_counter #(
    .CNT_W(CntW0), .WIN_LEN(WinLen0), .THRESH(Thresh0)
  ) u_dut0 (
    .sysClk(sysClk), .resetH(resetH), .enAH(enAH), .detAH(detAH),
    .clrOvfAH(clrOvfAH), .ovfAH(ovf0), .rpt(rpt0)
  );

  detect_event_counter #(
    .CNT_W(CntW1), .WIN_LEN(WinLen1), .THRESH(Thresh1)
  ) u_dut1 (
    .sysClk(sysClk), .resetH(resetH), .enAH(enAH), .detAH(detAH),
    .clrOvfAH(clrOvfAH), .ovfAH(ovf1), .rpt(rpt1)
  );

  always #5 sysClk = ~sysClk;

  logic       act_valid [2];
  logic       act_alarm [2];
  logic       act_ovf   [2];
  logic [7:0] act_cnt   [2];
  assign act_valid[0] = rpt0.rptValid;
  assign act_valid[1] = rpt1.rptValid;
  assign act_alarm[0] = rpt0.alarmAH;
  assign act_alarm[1] = rpt1.alarmAH;
  assign act_ovf[0]   = ovf0;
  assign act_ovf[1]   = ovf1;
  assign act_cnt[0]   = rpt0.rptCount;
  assign act_cnt[1]   = {5'b0, rpt1.rptCount};

  // Model state: run flag, position in window, events so far (unbounded),
  // pending report and its count, overflow flag.
  bit m_run [2];
  bit m_full[2];
  bit m_ovf [2];
  int m_pos [2];
  int m_evt [2];
  int m_cnt [2];

  function automatic int clip(input int total, input int w);
    int lim;
    lim = (1 << w);
`ifdef DETECT_CNT_SAT_EN
    return (total > lim - 1) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  // Apply inputs, advance the model by one cycle, wait for the edge.
  task automatic step(input logic en, input logic det, input logic rdy, input logic clr);
    enAH = en; detAH = det; rptReady = rdy; clrOvfAH = clr;
    for (int k = 0; k < 2; k++) begin
      int len, w, total;
      bit wend, drop;
      len = (k == 0) ? int'(WinLen0) : int'(WinLen1);
      w   = (k == 0) ? int'(CntW0) : int'(CntW1);
      if (resetH) begin
        m_run[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
        m_pos[k] = 0; m_evt[k] = 0; m_cnt[k] = 0;
      end else begin
        wend  = m_run[k] && (m_pos[k] == len - 1);
        total = m_evt[k] + ((m_run[k] && det) ? 1 : 0);
        drop  = wend && m_full[k] && !rdy;
        if (wend && !drop) begin
          m_full[k] = 1;
          m_cnt[k]  = clip(total, w);
        end else if (!wend && m_full[k] && rdy) begin
          m_full[k] = 0;
        end
        if (drop) m_ovf[k] = 1;
        else if (clr) m_ovf[k] = 0;
        if (m_run[k] && en && !wend) begin
          m_pos[k] = m_pos[k] + 1;
          m_evt[k] = total;
        end else begin
          m_pos[k] = 0;
          m_evt[k] = 0;
        end
        m_run[k] = en;
      end
    end
    @(posedge sysClk);
    #1;
  endtask

  task automatic do_reset();
    resetH = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    resetH = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    seen = 0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_valid[k] !== 1'b0 || act_cnt[k] !== 8'd0 || act_alarm[k] !== 1'b0 ||
          act_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut%0d: valid=%0b count=%0d alarm=%0b ovf=%0b, required all 0",
                 k, act_valid[k], act_cnt[k], act_alarm[k], act_ovf[k]);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (rpt0.rptValid !== 1'b0 || rpt1.rptValid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || rpt0.rptCount !== 8'd0 || rpt0.alarmAH !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: valid_seen=%0b count=%0d alarm=%0b ovf=%0b, required 0",
               seen, rpt0.rptCount, rpt0.alarmAH, ovf0);
    end
  endtask

  task automatic test_count_alarm();
    bit early, det;
    early = 0;
    do_reset();
    for (int i = 0; i <= 65; i++) begin
      det = (i == 1 || i == 10 || i == 20 || i == 40 || i == 64);
      step(1'b1, det, 1'b1, 1'b0);
      if (i < 64) begin
        if (rpt0.rptValid !== 1'b0) early = 1;
      end else if (i == 64) begin
        checks++;
        if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd5 || rpt0.alarmAH !== 1'b1) begin
          errors++;
          $display("FAIL count_alarm: valid=%0b count=%0d alarm=%0b, required 1/5/1",
                   rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH);
        end
      end else begin
        checks++;
        if (rpt0.rptValid !== 1'b0 || rpt0.alarmAH !== 1'b0) begin
          errors++;
          $display("FAIL count_accept: valid=%0b alarm=%0b, required 0/0",
                   rpt0.rptValid, rpt0.alarmAH);
        end
      end
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL count_latency: valid=1 before window end, required 0");
    end
  endtask

  task automatic test_backpressure();
    bit det;
    do_reset();
    for (int i = 0; i <= 129; i++) begin
      det = (i >= 5 && i <= 7) || (i >= 70 && i <= 76);
      step(1'b1, det, 1'b0, 1'(i == 129));
      if (i == 127 || i == 128 || i == 129) begin
        checks++;
        if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd3 || rpt0.alarmAH !== 1'b0 ||
            ovf0 !== 1'(i == 128)) begin
          errors++;
          $display("FAIL backpressure_%0d: valid=%0b count=%0d alarm=%0b ovf=%0b, required 1/3/0/%0b",
                   i, rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH, ovf0, (i == 128));
        end
      end
    end
  endtask

  task automatic test_accept_on_end();
    bit det, unstable;
    unstable = 0;
    do_reset();
    for (int i = 0; i <= 129; i++) begin
      det = (i == 3 || i == 4) || (i >= 70 && i <= 75);
      step(1'b1, det, 1'(i >= 128), 1'b0);
      if (i >= 65 && i <= 127) begin
        if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd2 || rpt0.alarmAH !== 1'b0)
          unstable = 1;
      end else if (i == 128) begin
        checks++;
        if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd6 || rpt0.alarmAH !== 1'b1 ||
            ovf0 !== 1'b0) begin
          errors++;
          $display("FAIL accept_on_end: valid=%0b count=%0d alarm=%0b ovf=%0b, required 1/6/1/0",
                   rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH, ovf0);
        end
      end else if (i == 129) begin
        checks++;
        if (rpt0.rptValid !== 1'b0) begin
          errors++;
          $display("FAIL accept_after_end: valid=%0b, required 0", rpt0.rptValid);
        end
      end
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL hold_stable: report changed while stalled, required 1/2/0");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i <= 64; i++) begin
      step(1'b1, 1'(i >= 1 && i <= 10), 1'b1, 1'b0);
      if (i == 16) begin
        checks++;
        if (rpt1.rptValid !== 1'b1 || rpt1.rptCount !== SatCnt || rpt1.alarmAH !== SatAlarm) begin
          errors++;
          $display("FAIL narrow_count: valid=%0b count=%0d alarm=%0b, required 1/%0d/%0b",
                   rpt1.rptValid, rpt1.rptCount, rpt1.alarmAH, SatCnt, SatAlarm);
        end
      end else if (i == 64) begin
        checks++;
        if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd10 || rpt0.alarmAH !== 1'b1) begin
          errors++;
          $display("FAIL wide_count: valid=%0b count=%0d alarm=%0b, required 1/10/1",
                   rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH);
        end
      end
    end
  endtask

  task automatic test_stop_at_end();
    bit spurious;
    spurious = 0;
    do_reset();
    for (int i = 0; i <= 64; i++) step(1'(i < 64), 1'(i == 5 || i == 64), 1'b0, 1'b0);
    checks++;
    if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd2 || rpt0.alarmAH !== 1'b0) begin
      errors++;
      $display("FAIL stop_at_end: valid=%0b count=%0d alarm=%0b, required 1/2/0",
               rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH);
    end
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (rpt0.rptValid !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL idle_no_report: valid=1 while idle, required 0");
    end
  endtask

  task automatic test_abort();
    bit changed;
    changed = 0;
    do_reset();
    for (int i = 0; i <= 95; i++) step(1'(i < 95), 1'(i == 2 || i == 70 || i == 80), 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (rpt0.rptValid !== 1'b1 || rpt0.rptCount !== 8'd1 || rpt0.alarmAH !== 1'b0 ||
          ovf0 !== 1'b0) changed = 1;
    end
    checks++;
    if (changed) begin
      errors++;
      $display("FAIL abort_pending: pending report disturbed, required 1/1/0 ovf 0");
    end
    resetH = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    resetH = 1'b0;
    checks++;
    if (rpt0.rptValid !== 1'b0 || rpt0.rptCount !== 8'd0 || rpt0.alarmAH !== 1'b0 ||
        ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: valid=%0b count=%0d alarm=%0b ovf=%0b, required all 0",
               rpt0.rptValid, rpt0.rptCount, rpt0.alarmAH, ovf0);
    end
  endtask

  task automatic test_random();
    logic        en;
    int unsigned dens;
    bit          exp_alarm;
    int          thr;
    en   = 1'b1;
    dens = 2;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(0, 4);
      if ($urandom_range(0, 199) == 0) en = !en;
      resetH = ($urandom_range(0, 999) == 0);
      step(en, 1'($urandom_range(0, 3) < dens), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
      for (int k = 0; k < 2; k++) begin
        thr       = (k == 0) ? int'(Thresh0) : int'(Thresh1);
        exp_alarm = m_full[k] && (m_cnt[k] >= thr);
        checks++;
        if (act_valid[k] !== m_full[k] || act_ovf[k] !== m_ovf[k] ||
            act_alarm[k] !== exp_alarm || (m_full[k] && act_cnt[k] !== 8'(m_cnt[k]))) begin
          errors++;
          $display("FAIL random_dut%0d cycle %0d: valid=%0b ovf=%0b count=%0d alarm=%0b, required valid=%0b ovf=%0b count=%0d alarm=%0b",
                   k, c, act_valid[k], act_ovf[k], act_cnt[k], act_alarm[k],
                   m_full[k], m_ovf[k], m_cnt[k], exp_alarm);
        end
      end
    end
    resetH = 1'b0;
  endtask

  initial begin
    resetH   = 1'b1;
    enAH     = 1'b0;
    detAH    = 1'b0;
    rptReady = 1'b0;
    clrOvfAH = 1'b0;
    test_reset();
    test_count_alarm();
    test_backpressure();
    test_accept_on_end();
    test_saturation();
    test_stop_at_end();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_event_counter.md
DETECT_EVENT_COUNTER -- requirements
Module: detect_event_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the event count and report in bits.
REQ-002 The block SHALL have parameter WIN_LEN, default 64, the window length in sysClk cycles; the legal range is 2..65535.
REQ-003 The block SHALL have parameter THRESH, default 4, the alarm threshold; the legal range is 1..2^CNT_W-1.
REQ-004 The block SHALL have port sysClk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-005 The block SHALL have port resetH, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enAH, input, 1 bit: run enable, active high.
REQ-007 The block SHALL have port detAH, input, 1 bit: the registered match pulse from the upstream sequence detector.
REQ-008 The block SHALL have port rptReady, input, 1 bit: the consumer accepts a report.
REQ-009 The block SHALL have port clrOvfAH, input, 1 bit: clears the overflow flag.
REQ-010 The block SHALL have port rptValid, output, 1 bit: a report is pending.
REQ-011 The block SHALL have port rptCount, output, CNT_W bits: the matches counted in the reported window.
REQ-012 The block SHALL have port alarmAH, output, 1 bit: the pending report meets the threshold.
REQ-013 The block SHALL have port ovfAH, output, 1 bit: sticky flag set when a report is dropped.

Function
REQ-014 The run FSM SHALL have states IDLE and RUN; IDLE->RUN when enAH=1; RUN->IDLE when enAH=0.
REQ-015 In IDLE, winCnt and evtCnt SHALL be held at 0.
REQ-016 In RUN, winCnt SHALL increment each cycle from 0 to WIN_LEN-1, then wrap to 0; the wrap cycle is "window end".
REQ-017 In RUN, evtCnt SHALL add 1 in every cycle with detAH=1, including the window-end cycle.
REQ-018 At window end, evtCnt SHALL clear to 0 on the next edge.
REQ-019 At window end, the closing total, including that cycle's detAH, SHALL be offered to the report register.
REQ-020 The report FSM SHALL have states EMPTY and FULL; rptValid=1 exactly in FULL.
REQ-021 EMPTY->FULL SHALL occur at the edge following window end, loading rptCount, so latency is 1 cycle.
REQ-022 FULL->EMPTY SHALL occur on an edge where rptValid=1 and rptReady=1 and no window end occurs that cycle.
REQ-023 If acceptance and window end coincide, the new report SHALL be loaded and the FSM SHALL stay FULL.
REQ-024 If window end occurs while in FULL with rptReady=0, the new report SHALL be dropped, rptCount SHALL be unchanged, and ovfAH SHALL be set.
REQ-025 rptCount and alarmAH SHALL remain stable while rptValid=1 and rptReady=0.
REQ-026 alarmAH SHALL be registered, equal to (rptCount >= THRESH), and valid only while rptValid=1; it SHALL be 0 in EMPTY.
REQ-027 ovfAH SHALL clear on clrOvfAH=1; if set and clear coincide, set SHALL win.
REQ-028 enAH=0 mid-window SHALL discard the partial window and leave a pending report untouched.
REQ-029 enAH=0 on a window-end cycle SHALL still issue that window's report.

Reset
REQ-030 While resetH=1 at an edge, the run FSM SHALL go to IDLE, the report FSM to EMPTY, and winCnt and evtCnt to 0.
REQ-031 While resetH=1 at an edge, rptValid, rptCount, alarmAH and ovfAH SHALL go to 0.
REQ-032 resetH SHALL take priority over all other inputs, including mid-window and mid-handshake.

Configuration
REQ-033 With DETECT_CNT_SAT_EN defined, evtCnt SHALL saturate at 2^CNT_W-1.
REQ-034 Without DETECT_CNT_SAT_EN, evtCnt SHALL wrap modulo 2^CNT_W.

Structure
REQ-035 Package detect_pkg SHALL hold the run and report FSM state encodings and the default values of CNT_W, WIN_LEN and THRESH.
REQ-036 The window timer SHALL be a sub-module win_timer that outputs a one-cycle winEnd pulse and clears on !enAH.

Verification
REQ-037 Reset/idle: resetH=1 for 2 cycles, then enAH=0 for 100 cycles -> all outputs 0, rptValid never asserted.
REQ-038 Count and alarm: WIN_LEN=64, THRESH=4, detAH pulsed 5 times in window 0, rptReady=1 -> rptValid high for 1 cycle at cycle 64 after enable, rptCount=5, alarmAH=1.
REQ-039 Backpressure: rptReady=0 over 2 window ends with counts 3 then 7 -> rptCount stays 3, alarmAH=0, ovfAH=1; clrOvfAH pulse -> ovfAH=0.
REQ-040 Simultaneous accept and window end: rptReady=1 exactly on the window-end cycle -> rptValid stays 1, new count loaded, ovfAH=0.
REQ-041 Saturation/wrap: CNT_W=3, detAH=1 for 10 cycles in one window -> rptCount=7 with DETECT_CNT_SAT_EN, rptCount=2 without.
REQ-042 Mid-operation abort: enAH dropped at winCnt=30 with 2 detections, then resetH asserted during FULL -> no report for the partial window, and all outputs 0 the cycle after reset.
